// File: rtl/demux1to2_stream.sv
// -----------------------------------------------------------------------------
// demux1to2_stream
//
// Purpose:
//   Splits one valid/ready word stream into two output channels. Each input
//   word carries a select bit: 1 steers it to channel A, 0 steers it to
//   channel B (same polarity as the team's 2:1 muxes). Every channel owns a
//   2-entry FIFO, so a stalled consumer soaks up two words before it pushes
//   back on the shared input. Per-channel counters record how many words
//   were accepted for each destination since reset.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_data    input word (WIDTH bits)
//   in_sel     destination select: 1 = channel A, 0 = channel B
//   in_valid   input word present
//   in_ready   block accepts the input word this cycle
//   a_data     channel A head word (registered)
//   a_valid    channel A head word valid
//   a_ready    channel A consumer accepts
//   b_data     channel B head word (registered)
//   b_valid    channel B head word valid
//   b_ready    channel B consumer accepts
//   a_count    words accepted for A since reset, wraps modulo 2^CW
//   b_count    words accepted for B since reset, wraps modulo 2^CW
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// demux1to2_stream_fifo2
//
// Purpose:
//   Two-entry FIFO used once per output channel: a head register that drives
//   the output directly, a second register behind it, and a 2-bit occupancy.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_push       write i_data this edge (ignored while full)
//   i_data       word to write
//   i_pop        consumer takes the head this edge (ignored while empty)
//   o_valid      head holds a word
//   o_full       both entries hold words
//   o_data       head word
// -----------------------------------------------------------------------------
module demux1to2_stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_second;

  logic w_push;
  logic w_pop;

  // Gate the requests locally so the FIFO can never overrun or underrun,
  // whatever the surrounding logic does.
  assign w_push  = i_push && (r_occ != 2'd2);
  assign w_pop   = i_pop && (r_occ != 2'd0);

  assign o_valid = (r_occ != 2'd0);
  assign o_full  = (r_occ == 2'd2);
  assign o_data  = r_head;

  // Data registers load only on a push into an empty slot or on a shift, so
  // the head stays frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ    <= 2'd0;
      r_head   <= '0;
      r_second <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= i_data;
            r_occ  <= 2'd1;
          end else begin
            r_second <= i_data;
            r_occ    <= 2'd2;
          end
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_head <= r_second;
            r_occ  <= 2'd1;
          end else begin
            r_occ <= 2'd0;
          end
        end
        // Push and pop together is only possible at occupancy 1: the new
        // word replaces the departing head and occupancy is unchanged.
        2'b11: begin
          r_head <= i_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

module demux1to2_stream #(
  parameter int WIDTH = 8,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);

  logic w_fullA;
  logic w_fullB;
  logic w_accept;
  logic w_pushA;
  logic w_pushB;

  logic [CW-1:0] r_countA;
  logic [CW-1:0] r_countB;

  // in_ready looks only at the selected channel's occupancy, never at the
  // consumer readies, so there is no combinational ready path through here.
  assign in_ready = in_sel ? !w_fullA : !w_fullB;
  assign w_accept = in_valid && in_ready;
  assign w_pushA  = w_accept && in_sel;
  assign w_pushB  = w_accept && !in_sel;

  demux1to2_stream_fifo2 #(.WIDTH(WIDTH)) u_fifoA (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_pushA),
    .i_data  (in_data),
    .i_pop   (a_ready),
    .o_valid (a_valid),
    .o_full  (w_fullA),
    .o_data  (a_data)
  );

  demux1to2_stream_fifo2 #(.WIDTH(WIDTH)) u_fifoB (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_pushB),
    .i_data  (in_data),
    .i_pop   (b_ready),
    .o_valid (b_valid),
    .o_full  (w_fullB),
    .o_data  (b_data)
  );

  // Accepted-word counters; they simply wrap at 2^CW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_countA <= '0;
      r_countB <= '0;
    end else begin
      if (w_pushA) begin
        r_countA <= r_countA + CW'(1);
      end
      if (w_pushB) begin
        r_countB <= r_countB + CW'(1);
      end
    end
  end

  assign a_count = r_countA;
  assign b_count = r_countB;

endmodule

// File: tb/tb_demux1to2_stream.sv
// -----------------------------------------------------------------------------
// tb_demux1to2_stream
//
// Purpose:
//   Self-checking bench for demux1to2_stream. A queue per channel models the
//   buffered words; each cycle the outputs are compared with the queue heads,
//   the queue sizes and the expected counters. Directed scenarios are
//   followed by randomized traffic. CW is set to 4 so counter wrap is cheap
//   to reach.
// -----------------------------------------------------------------------------
module tb_demux1to2_stream;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  logic [WIDTH-1:0] qA[$];
  logic [WIDTH-1:0] qB[$];
  logic [CW-1:0]    expCountA;
  logic [CW-1:0]    expCountB;
  logic             lastAccepted;

  int checkCount = 0;
  int passCount  = 0;

  demux1to2_stream #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every output against the queue model.
  task automatic checkAll(input string phase);
    int occSel;
    occSel = in_sel ? qA.size() : qB.size();
    checkOutput({phase, " in_ready"}, 32'(in_ready), 32'(occSel != 2));
    checkOutput({phase, " a_valid"}, 32'(a_valid), 32'(qA.size() != 0));
    checkOutput({phase, " b_valid"}, 32'(b_valid), 32'(qB.size() != 0));
    if (qA.size() != 0) checkOutput({phase, " a_data"}, 32'(a_data), 32'(qA[0]));
    if (qB.size() != 0) checkOutput({phase, " b_data"}, 32'(b_data), 32'(qB[0]));
    checkOutput({phase, " a_count"}, 32'(a_count), 32'(expCountA));
    checkOutput({phase, " b_count"}, 32'(b_count), 32'(expCountB));
  endtask

  // Drive one cycle of stimulus, check at the falling edge, then advance the
  // model on the rising edge. Returns at 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d,
                               input logic ar, input logic br, input string phase);
    logic acc;
    logic popA;
    logic popB;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    @(negedge clk);
    checkAll(phase);
    acc  = v && ((s ? qA.size() : qB.size()) != 2);
    popA = (qA.size() != 0) && ar;
    popB = (qB.size() != 0) && br;
    @(posedge clk);
    if (popA) void'(qA.pop_front());
    if (popB) void'(qB.pop_front());
    if (acc) begin
      if (s) begin
        qA.push_back(d);
        expCountA = expCountA + CW'(1);
      end else begin
        qB.push_back(d);
        expCountB = expCountB + CW'(1);
      end
    end
    lastAccepted = acc;
    #1;
  endtask

  // Assert reset immediately (asynchronously), check the cleared state before
  // any clock edge, then release on a falling edge.
  task automatic resetDut();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    qA.delete();
    qB.delete();
    expCountA = '0;
    expCountB = '0;
    checkOutput("reset a_valid", 32'(a_valid), 32'd0);
    checkOutput("reset b_valid", 32'(b_valid), 32'd0);
    checkOutput("reset a_data", 32'(a_data), 32'd0);
    checkOutput("reset b_data", 32'(b_data), 32'd0);
    checkOutput("reset a_count", 32'(a_count), 32'd0);
    checkOutput("reset b_count", 32'(b_count), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic             curV;
    logic             curS;
    logic [WIDTH-1:0] curD;

    rst_n        = 1'b1;
    in_valid     = 1'b0;
    in_sel       = 1'b0;
    in_data      = '0;
    a_ready      = 1'b1;
    b_ready      = 1'b1;
    expCountA    = '0;
    expCountB    = '0;
    lastAccepted = 1'b0;

    #2;
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "idle");

    // Steering
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b1, 1'b1, "steer");
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b1, 1'b1, "steer");
    applyStimulus(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, "steer");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "steer drain");
    checkOutput("steer a_count", 32'(a_count), 32'd2);
    checkOutput("steer b_count", 32'(b_count), 32'd1);

    // Back-pressure on A
    applyStimulus(1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, "bp");
    applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, "bp");
    checkOutput("bp third in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, "bp stall");
    applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, "bp stall");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, "bp release");
      if (lastAccepted) break;
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "bp drain");

    // Independence: A full and stalled, B still accepts
    applyStimulus(1'b1, 1'b1, 8'hC0, 1'b0, 1'b1, "indep");
    applyStimulus(1'b1, 1'b1, 8'hC1, 1'b0, 1'b1, "indep");
    applyStimulus(1'b1, 1'b0, 8'h5B, 1'b0, 1'b1, "indep");
    checkOutput("indep b_valid", 32'(b_valid), 32'd1);
    checkOutput("indep b_data", 32'(b_data), 32'h5B);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "indep drain");

    // Push and pop together at occupancy 1
    applyStimulus(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, "pushpop");
    applyStimulus(1'b1, 1'b1, 8'h02, 1'b1, 1'b1, "pushpop");
    checkOutput("pushpop a_valid", 32'(a_valid), 32'd1);
    checkOutput("pushpop a_data", 32'(a_data), 32'h02);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "pushpop hold");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "pushpop drain");

    // Asynchronous reset with A full, applied mid-cycle
    applyStimulus(1'b1, 1'b1, 8'hE0, 1'b0, 1'b1, "async");
    applyStimulus(1'b1, 1'b1, 8'hE1, 1'b0, 1'b1, "async");
    #2;
    resetDut();

    // Counter wrap: 17 words to B with CW = 4
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, WIDTH'(i + 8'h40), 1'b1, 1'b1, "wrap");
    checkOutput("wrap b_count", 32'(b_count), 32'd1);
    checkOutput("wrap a_count", 32'(a_count), 32'd0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "wrap drain");

    // Random traffic; the producer holds its word until it is accepted.
    curV = 1'b0;
    curS = 1'b0;
    curD = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(curV && !lastAccepted)) begin
        curV = ($urandom_range(0, 3) != 0);
        curS = 1'($urandom_range(0, 1));
        curD = WIDTH'($urandom);
      end
      applyStimulus(curV, curS, curD, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0), "rand");
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "final drain");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
